// File: rtl/fpu_bf16_pkg.sv
// Shared definitions for the bfloat16 FPU arbiter: op codes, flag positions and FSM states.
// Used by fpu_bf16_arbiter and fpu_rr_arb2.
package fpu_bf16_pkg;

    localparam logic [4:0] FADD   = 5'd0;
    localparam logic [4:0] FSUB   = 5'd1;
    localparam logic [4:0] FMUL   = 5'd2;
    localparam logic [4:0] FMADD  = 5'd3;
    localparam logic [4:0] FMSUB  = 5'd4;
    localparam logic [4:0] FNMADD = 5'd5;
    localparam logic [4:0] FNMSUB = 5'd6;
    localparam logic [4:0] FMIN   = 5'd7;
    localparam logic [4:0] FMAX   = 5'd8;
    localparam logic [4:0] FEQ    = 5'd9;
    localparam logic [4:0] FLT    = 5'd10;
    localparam logic [4:0] FLE    = 5'd11;
    localparam logic [4:0] FCLASS = 5'd12;
    localparam logic [4:0] F2I    = 5'd13;
    localparam logic [4:0] I2F    = 5'd14;
    localparam logic [4:0] FSGNJ  = 5'd15;
    localparam logic [4:0] FMV    = 5'd16;

    localparam logic [15:0] BF16_QNAN = 16'h7FC0;

    // Exception flag bit positions within the 5-bit {NV,DZ,OF,UF,NX} vector.
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [4:0] FLAGS_TIMEOUT = 5'(1 << FLAG_NV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fpu_rr_arb2.sv
// Combinational two-way round-robin grant: a lone requester always wins,
// and on contention the requester that was not served last wins.
module fpu_rr_arb2
    import fpu_bf16_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |valid;
        grant_idx   = 1'b0;
        if (valid == 2'b11) begin
            grant_idx = ~last_grant;
        end else if (valid[1]) begin
            grant_idx = 1'b1;
        end
    end

endmodule

// File: rtl/fpu_bf16_arbiter.sv
// Shares one multi-cycle bfloat16 FPU between two requesters with a watchdog abort.
// Optional macro FPU_ARB_PERF_EN adds per-requester op counters and a timeout counter.
module fpu_bf16_arbiter
    import fpu_bf16_pkg::*;
#(
    parameter int OP_W           = 5,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [1:0]          req_valid_i,
    output logic [1:0]          req_ready_o,
    input  logic [2*OP_W-1:0]   req_op_i,
    input  logic [2*DATA_W-1:0] req_a_i,
    input  logic [2*DATA_W-1:0] req_b_i,
    input  logic [2*DATA_W-1:0] req_c_i,
    output logic [1:0]          resp_valid_o,
    input  logic [1:0]          resp_ready_i,
    output logic [DATA_W-1:0]   resp_data_o,
    output logic [4:0]          resp_flags_o,
    output logic                resp_err_o,
    output logic                fpu_start_o,
    output logic [OP_W-1:0]     fpu_op_o,
    output logic [DATA_W-1:0]   fpu_a_o,
    output logic [DATA_W-1:0]   fpu_b_o,
    output logic [DATA_W-1:0]   fpu_c_o,
    input  logic                fpu_done_i,
    input  logic [DATA_W-1:0]   fpu_result_i,
    input  logic [4:0]          fpu_flags_i,
    output logic                busy_o
`ifdef FPU_ARB_PERF_EN
    ,
    output logic [31:0]         perf_ops_o,
    output logic [7:0]          perf_timeouts_o
`endif
);

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    arb_state_t  state, next_state;
    logic        owner;
    logic        last_grant;
    logic [15:0] timer;
    logic        grant_valid;
    logic        grant_idx;
    logic        capture;
    logic        load_done;
    logic        load_timeout;
    logic        resp_hs;

    fpu_rr_arb2 u_arb (
        .valid       (req_valid_i),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Done takes priority over watchdog expiry when both land in the same cycle.
    always_comb begin
        next_state   = state;
        capture      = 1'b0;
        load_done    = 1'b0;
        load_timeout = 1'b0;
        resp_hs      = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    capture    = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: next_state = WAIT;
            WAIT: begin
                if (fpu_done_i) begin
                    load_done  = 1'b1;
                    next_state = RESP;
                end else if (timer == TIMER_LAST) begin
                    load_timeout = 1'b1;
                    next_state   = RESP;
                end
            end
            RESP: begin
                if (resp_ready_i[owner]) begin
                    resp_hs    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign req_ready_o  = (state == IDLE && grant_valid) ? onehot2(grant_idx) : 2'b00;
    assign resp_valid_o = (state == RESP) ? onehot2(owner) : 2'b00;
    assign fpu_start_o  = (state == ISSUE);
    assign busy_o       = (state != IDLE);

    // last_grant resets to 1 so that the first contended grant goes to requester 0.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            timer        <= '0;
            fpu_op_o     <= '0;
            fpu_a_o      <= '0;
            fpu_b_o      <= '0;
            fpu_c_o      <= '0;
            resp_data_o  <= '0;
            resp_flags_o <= '0;
            resp_err_o   <= 1'b0;
        end else begin
            if (capture) begin
                owner      <= grant_idx;
                last_grant <= grant_idx;
                fpu_op_o   <= grant_idx ? req_op_i[OP_W +: OP_W]   : req_op_i[0 +: OP_W];
                fpu_a_o    <= grant_idx ? req_a_i[DATA_W +: DATA_W] : req_a_i[0 +: DATA_W];
                fpu_b_o    <= grant_idx ? req_b_i[DATA_W +: DATA_W] : req_b_i[0 +: DATA_W];
                fpu_c_o    <= grant_idx ? req_c_i[DATA_W +: DATA_W] : req_c_i[0 +: DATA_W];
            end
            if (state == ISSUE) begin
                timer <= '0;
            end else if (state == WAIT) begin
                timer <= timer + 16'd1;
            end
            if (load_done) begin
                resp_data_o  <= fpu_result_i;
                resp_flags_o <= fpu_flags_i;
                resp_err_o   <= 1'b0;
            end else if (load_timeout) begin
                resp_data_o  <= DATA_W'(BF16_QNAN);
                resp_flags_o <= FLAGS_TIMEOUT;
                resp_err_o   <= 1'b1;
            end
        end
    end

`ifdef FPU_ARB_PERF_EN
    logic [15:0] ops0, ops1;
    logic [7:0]  timeouts;

    // Op counters wrap; the timeout counter saturates so a stuck FPU stays visible.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ops0     <= '0;
            ops1     <= '0;
            timeouts <= '0;
        end else begin
            if (resp_hs && !owner) begin
                ops0 <= ops0 + 16'd1;
            end
            if (resp_hs && owner) begin
                ops1 <= ops1 + 16'd1;
            end
            if (load_timeout && timeouts != 8'hFF) begin
                timeouts <= timeouts + 8'd1;
            end
        end
    end

    assign perf_ops_o      = {ops1, ops0};
    assign perf_timeouts_o = timeouts;
`endif

endmodule

// File: tb/tb_fpu_bf16_arbiter.sv
// Directed self-checking bench for fpu_bf16_arbiter with TIMEOUT_CYCLES=8;
// the FPU side is driven by hand in each step.
module tb_fpu_bf16_arbiter;
    import fpu_bf16_pkg::*;

    localparam int OP_W   = 5;
    localparam int DATA_W = 16;
    localparam int TO     = 8;

    logic                wb_clk_i = 1'b0;
    logic                wb_rst_i;
    logic [1:0]          req_valid_i;
    logic [1:0]          req_ready_o;
    logic [2*OP_W-1:0]   req_op_i;
    logic [2*DATA_W-1:0] req_a_i, req_b_i, req_c_i;
    logic [1:0]          resp_valid_o;
    logic [1:0]          resp_ready_i;
    logic [DATA_W-1:0]   resp_data_o;
    logic [4:0]          resp_flags_o;
    logic                resp_err_o;
    logic                fpu_start_o;
    logic [OP_W-1:0]     fpu_op_o;
    logic [DATA_W-1:0]   fpu_a_o, fpu_b_o, fpu_c_o;
    logic                fpu_done_i;
    logic [DATA_W-1:0]   fpu_result_i;
    logic [4:0]          fpu_flags_i;
    logic                busy_o;
`ifdef FPU_ARB_PERF_EN
    logic [31:0]         perf_ops_o;
    logic [7:0]          perf_timeouts_o;
`endif

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    fpu_bf16_arbiter #(
        .OP_W           (OP_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_i        (wb_rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_op_i        (req_op_i),
        .req_a_i         (req_a_i),
        .req_b_i         (req_b_i),
        .req_c_i         (req_c_i),
        .resp_valid_o    (resp_valid_o),
        .resp_ready_i    (resp_ready_i),
        .resp_data_o     (resp_data_o),
        .resp_flags_o    (resp_flags_o),
        .resp_err_o      (resp_err_o),
        .fpu_start_o     (fpu_start_o),
        .fpu_op_o        (fpu_op_o),
        .fpu_a_o         (fpu_a_o),
        .fpu_b_o         (fpu_b_o),
        .fpu_c_o         (fpu_c_o),
        .fpu_done_i      (fpu_done_i),
        .fpu_result_i    (fpu_result_i),
        .fpu_flags_i     (fpu_flags_i),
        .busy_o          (busy_o)
`ifdef FPU_ARB_PERF_EN
        ,
        .perf_ops_o      (perf_ops_o),
        .perf_timeouts_o (perf_timeouts_o)
`endif
    );

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input int idx, input logic [4:0] op,
                                  input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        req_valid_i[idx]          = 1'b1;
        req_op_i[idx*OP_W +: OP_W] = op;
        req_a_i[idx*DATA_W +: DATA_W] = a;
        req_b_i[idx*DATA_W +: DATA_W] = b;
        req_c_i[idx*DATA_W +: DATA_W] = c;
    endtask

    task automatic resp_handshake(input int idx);
        resp_ready_i[idx] = 1'b1;
        tick();
        resp_ready_i = 2'b00;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=hang expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int n;
        wb_rst_i     = 1'b1;
        req_valid_i  = 2'b00;
        req_op_i     = '0;
        req_a_i      = '0;
        req_b_i      = '0;
        req_c_i      = '0;
        resp_ready_i = 2'b00;
        fpu_done_i   = 1'b0;
        fpu_result_i = '0;
        fpu_flags_i  = '0;

        // Reset state
        tick();
        tick();
        check_output("rst_busy", 32'(busy_o), 32'h0);
        check_output("rst_start", 32'(fpu_start_o), 32'h0);
        check_output("rst_resp_valid", 32'(resp_valid_o), 32'h0);
        check_output("rst_data", 32'(resp_data_o), 32'h0);
        wb_rst_i = 1'b0;
        tick();

        // Single FADD 2.0 + 3.0 from req0, FPU latency 3
        apply_stimulus(0, FADD, 16'h4000, 16'h4040, 16'h0000);
        #1;
        check_output("single_ready", 32'(req_ready_o), 32'h1);
        tick();
        req_valid_i = 2'b00;
        check_output("single_start", 32'(fpu_start_o), 32'h1);
        check_output("single_busy", 32'(busy_o), 32'h1);
        check_output("single_a", 32'(fpu_a_o), 32'h4000);
        check_output("single_b", 32'(fpu_b_o), 32'h4040);
        repeat (3) tick();
        check_output("single_start_low", 32'(fpu_start_o), 32'h0);
        fpu_done_i   = 1'b1;
        fpu_result_i = 16'h40A0;
        fpu_flags_i  = 5'b00000;
        tick();
        fpu_done_i = 1'b0;
        check_output("single_resp_valid", 32'(resp_valid_o), 32'h1);
        check_output("single_data", 32'(resp_data_o), 32'h40A0);
        check_output("single_flags", 32'(resp_flags_o), 32'h0);
        check_output("single_err", 32'(resp_err_o), 32'h0);
        resp_handshake(0);
        check_output("single_idle", 32'(busy_o), 32'h0);

        // Contention after a fresh reset: grants alternate starting with req0
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        tick();
        apply_stimulus(0, FSUB, 16'h3F80, 16'h0001, 16'h0000);
        apply_stimulus(1, FMAX, 16'h4000, 16'h0002, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            #1;
            check_output($sformatf("rr_ready_%0d", i), 32'(req_ready_o), (i % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            check_output($sformatf("rr_a_%0d", i), 32'(fpu_a_o), (i % 2 == 0) ? 32'h3F80 : 32'h4000);
            tick();
            fpu_done_i   = 1'b1;
            fpu_result_i = 16'h1000 + 16'(i);
            tick();
            fpu_done_i = 1'b0;
            check_output($sformatf("rr_resp_%0d", i), 32'(resp_valid_o), (i % 2 == 0) ? 32'h1 : 32'h2);
            check_output($sformatf("rr_data_%0d", i), 32'(resp_data_o), 32'h1000 + 32'(i));
            resp_handshake(i % 2);
        end
        req_valid_i = 2'b00;

        // Watchdog timeout on req0, FPU never answers
        apply_stimulus(0, FSUB, 16'h4000, 16'h3F80, 16'h0000);
        tick();
        req_valid_i = 2'b00;
        check_output("to_start", 32'(fpu_start_o), 32'h1);
        tick();
        n = 0;
        while (resp_valid_o == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        check_output("to_wait_cycles", 32'(n), 32'd8);
        check_output("to_resp_valid", 32'(resp_valid_o), 32'h1);
        check_output("to_data", 32'(resp_data_o), 32'h7FC0);
        check_output("to_flags", 32'(resp_flags_o), 32'h10);
        check_output("to_err", 32'(resp_err_o), 32'h1);
        resp_handshake(0);

        // Next request after a timeout is serviced normally
        apply_stimulus(1, FMIN, 16'h3F80, 16'h4000, 16'h0000);
        #1;
        check_output("rec_ready", 32'(req_ready_o), 32'h2);
        tick();
        req_valid_i = 2'b00;
        check_output("rec_op", 32'(fpu_op_o), 32'(FMIN));
        tick();
        tick();
        fpu_done_i   = 1'b1;
        fpu_result_i = 16'h3F80;
        fpu_flags_i  = 5'b00001;
        tick();
        fpu_done_i = 1'b0;
        check_output("rec_resp_valid", 32'(resp_valid_o), 32'h2);
        check_output("rec_data", 32'(resp_data_o), 32'h3F80);
        check_output("rec_flags", 32'(resp_flags_o), 32'h01);
        check_output("rec_err", 32'(resp_err_o), 32'h0);
        resp_handshake(1);

        // Done in the same cycle as expiry: done wins
        apply_stimulus(0, FMADD, 16'h4000, 16'h4000, 16'h3F80);
        tick();
        req_valid_i = 2'b00;
        tick();
        repeat (TO - 1) tick();
        check_output("col_no_resp_yet", 32'(resp_valid_o), 32'h0);
        fpu_done_i   = 1'b1;
        fpu_result_i = 16'h4120;
        fpu_flags_i  = 5'b00000;
        tick();
        fpu_done_i = 1'b0;
        check_output("col_resp_valid", 32'(resp_valid_o), 32'h1);
        check_output("col_data", 32'(resp_data_o), 32'h4120);
        check_output("col_err", 32'(resp_err_o), 32'h0);
        check_output("col_flags", 32'(resp_flags_o), 32'h0);
        resp_handshake(0);

        // Stray done while idle is ignored
        fpu_done_i = 1'b1;
        tick();
        fpu_done_i = 1'b0;
        check_output("idle_done_busy", 32'(busy_o), 32'h0);
        check_output("idle_done_resp", 32'(resp_valid_o), 32'h0);

        // Response backpressure on req1 FMUL 2.0 * 2.0 with req0 waiting
        apply_stimulus(1, FMUL, 16'h4000, 16'h4000, 16'h0000);
        apply_stimulus(0, FADD, 16'h3F80, 16'h3F80, 16'h0000);
        #1;
        check_output("bp_ready", 32'(req_ready_o), 32'h2);
        tick();
        req_valid_i[1] = 1'b0;
        check_output("bp_op", 32'(fpu_op_o), 32'(FMUL));
        tick();
        fpu_done_i   = 1'b1;
        fpu_result_i = 16'h4080;
        fpu_flags_i  = 5'b00000;
        tick();
        fpu_done_i   = 1'b0;
        fpu_result_i = 16'hDEAD;
        resp_ready_i = 2'b01;
        for (int i = 0; i < 10; i++) begin
            check_output($sformatf("bp_data_%0d", i), 32'(resp_data_o), 32'h4080);
            check_output($sformatf("bp_req_ready_%0d", i), 32'(req_ready_o), 32'h0);
            tick();
        end
        check_output("bp_busy", 32'(busy_o), 32'h1);
        check_output("bp_resp_valid", 32'(resp_valid_o), 32'h2);
        resp_ready_i = 2'b00;
        resp_handshake(1);
        check_output("bp_idle", 32'(busy_o), 32'h0);
        check_output("bp_next_ready", 32'(req_ready_o), 32'h1);
        req_valid_i = 2'b00;
        #1;
        check_output("withdraw_ready", 32'(req_ready_o), 32'h0);
        tick();
        check_output("withdraw_no_capture", 32'(busy_o), 32'h0);

        // Reset in the middle of WAIT drops the op
        apply_stimulus(0, FMADD, 16'h3F80, 16'h4000, 16'h4040);
        tick();
        req_valid_i = 2'b00;
        check_output("mid_c", 32'(fpu_c_o), 32'h4040);
        tick();
        tick();
`ifdef FPU_ARB_PERF_EN
        check_output("perf_ops", perf_ops_o, {16'd6, 16'd6});
        check_output("perf_timeouts", 32'(perf_timeouts_o), 32'd1);
`endif
        wb_rst_i = 1'b1;
        #1;
        check_output("mid_rst_busy", 32'(busy_o), 32'h0);
        check_output("mid_rst_a", 32'(fpu_a_o), 32'h0);
        check_output("mid_rst_data", 32'(resp_data_o), 32'h0);
        check_output("mid_rst_start", 32'(fpu_start_o), 32'h0);
`ifdef FPU_ARB_PERF_EN
        check_output("mid_rst_perf_ops", perf_ops_o, 32'h0);
        check_output("mid_rst_perf_to", 32'(perf_timeouts_o), 32'h0);
`endif
        tick();
        wb_rst_i     = 1'b0;
        fpu_done_i   = 1'b1;
        fpu_result_i = 16'h4120;
        tick();
        fpu_done_i = 1'b0;
        tick();
        check_output("late_done_busy", 32'(busy_o), 32'h0);
        check_output("late_done_resp", 32'(resp_valid_o), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
